// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port, with a one-entry commit stage and a pending-write scoreboard.
// Build option: define WB_ARB_RR_EN for round-robin arbitration instead of fixed L-over-A priority.
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            i_CLK,
  input  logic            i_RST,
  input  logic            i_L_VALID,
  output logic            o_L_READY,
  input  logic [4:0]      i_L_PTR,
  input  logic [XLEN-1:0] i_L_DATA,
  input  logic            i_A_VALID,
  output logic            o_A_READY,
  input  logic [4:0]      i_A_PTR,
  input  logic [XLEN-1:0] i_A_DATA,
  input  logic            i_ISSUE_VALID,
  input  logic [4:0]      i_ISSUE_PTR,
  output logic            o_WE,
  output logic [4:0]      o_RD_PTR,
  output logic [XLEN-1:0] o_RD,
  output logic [NREG-1:0] o_PENDING
);

  // Handshake: a port transfers when VALID && READY in the same cycle; READY is a
  // function of the VALIDs and arbitration state only, and requesters hold PTR/DATA until READY.
  logic w_l_grant;
  logic w_a_grant;

`ifdef WB_ARB_RR_EN
  logic r_rr_a;  // 1: A has priority on the next contended cycle

  always_comb begin
    w_l_grant = 1'b0;
    w_a_grant = 1'b0;
    if (!i_RST) begin
      if (i_L_VALID && i_A_VALID) begin
        w_l_grant = !r_rr_a;
        w_a_grant = r_rr_a;
      end else begin
        w_l_grant = i_L_VALID;
        w_a_grant = i_A_VALID;
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST)          r_rr_a <= 1'b0;
    else if (w_l_grant) r_rr_a <= 1'b1;
    else if (w_a_grant) r_rr_a <= 1'b0;
  end
`else
  assign w_l_grant = i_L_VALID && !i_RST;
  assign w_a_grant = i_A_VALID && !i_L_VALID && !i_RST;
`endif

  assign o_L_READY = w_l_grant;
  assign o_A_READY = w_a_grant;

  logic            r_we;
  logic [4:0]      r_rd_ptr;
  logic [XLEN-1:0] r_rd;
  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;

  // The regfile never stalls, so the commit stage simply reloads every cycle.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_we     <= 1'b0;
      r_rd_ptr <= 5'd0;
      r_rd     <= '0;
    end else if (w_l_grant) begin
      r_we     <= (i_L_PTR != 5'd0);
      r_rd_ptr <= i_L_PTR;
      r_rd     <= i_L_DATA;
    end else if (w_a_grant) begin
      r_we     <= (i_A_PTR != 5'd0);
      r_rd_ptr <= i_A_PTR;
      r_rd     <= i_A_DATA;
    end else begin
      r_we     <= 1'b0;
    end
  end

  // Bit 0 is never set, so it stays at its reset value of 0.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int n = 1; n < NREG; n++) begin
      if (i_ISSUE_VALID && (i_ISSUE_PTR == 5'(n))) w_set[n] = 1'b1;
      if (r_we && (r_rd_ptr == 5'(n)))             w_clr[n] = 1'b1;
    end
  end

  // OR-ing the set after the clear makes a same-cycle set win.
  always_ff @(posedge i_CLK) begin
    if (i_RST) r_pending <= '0;
    else       r_pending <= (r_pending & ~w_clr) | w_set;
  end

  assign o_WE      = r_we;
  assign o_RD_PTR  = r_rd_ptr;
  assign o_RD      = r_rd;
  assign o_PENDING = r_pending;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single writes, contention, x0 drop, scoreboard, mid-run reset, arbitration order.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        l_valid, l_ready, a_valid, a_ready;
  logic [4:0]  l_ptr, a_ptr, issue_ptr, rd_ptr;
  logic [31:0] l_data, a_data, rd;
  logic        issue_valid, we;
  logic [31:0] pending;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] rf [32];
  logic [36:0] exp_q [$];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
    .i_CLK(clk), .i_RST(rst),
    .i_L_VALID(l_valid), .o_L_READY(l_ready), .i_L_PTR(l_ptr), .i_L_DATA(l_data),
    .i_A_VALID(a_valid), .o_A_READY(a_ready), .i_A_PTR(a_ptr), .i_A_DATA(a_data),
    .i_ISSUE_VALID(issue_valid), .i_ISSUE_PTR(issue_ptr),
    .o_WE(we), .o_RD_PTR(rd_ptr), .o_RD(rd), .o_PENDING(pending)
  );

  // Shadow regfile: commits on the negedge of the cycle in which WE is high.
  always @(negedge clk) if (we === 1'b1) rf[rd_ptr] <= rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic idle_inputs();
    l_valid = 1'b0; a_valid = 1'b0; issue_valid = 1'b0;
  endtask

  task automatic check_commit(input string tag, input logic exp_we, input logic [4:0] exp_ptr,
                              input logic [31:0] exp_rd);
    check({tag, "_we"},  32'(we),     32'(exp_we));
    check({tag, "_ptr"}, 32'(rd_ptr), 32'(exp_ptr));
    check({tag, "_rd"},  rd,          exp_rd);
  endtask

  initial begin
    logic        exp_l;
    logic [36:0] e;
    logic [4:0]  lp, ap;
    logic [31:0] ld, ad;

    rst = 1'b1; idle_inputs();
    l_ptr = 5'd1; l_data = 32'hAA; a_ptr = 5'd2; a_data = 32'hBB; issue_ptr = 5'd0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;

    // Reset with both requesters valid
    @(negedge clk);
    l_valid = 1'b1; a_valid = 1'b1;
    #1;
    check("rst_l_ready", 32'(l_ready), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd0);
    @(negedge clk);
    check_commit("rst1", 1'b0, 5'd0, 32'h0);
    check("rst1_pending", pending, 32'h0);
    @(negedge clk);
    check_commit("rst2", 1'b0, 5'd0, 32'h0);
    check("rst2_a_ready", 32'(a_ready), 32'd0);

    // First grant after reset goes to L
    rst = 1'b0;
    #1;
    check("post_rst_l_ready", 32'(l_ready), 32'd1);
    check("post_rst_a_ready", 32'(a_ready), 32'd0);
    @(negedge clk);
    check_commit("post_rst_l", 1'b1, 5'd1, 32'hAA);
    l_valid = 1'b0;
    #1;
    check("post_rst_a_ready2", 32'(a_ready), 32'd1);
    @(negedge clk);
    check_commit("post_rst_a", 1'b1, 5'd2, 32'hBB);
    idle_inputs();
    @(negedge clk);
    check_commit("hold", 1'b0, 5'd2, 32'hBB);

    // Single ALU write
    a_valid = 1'b1; a_ptr = 5'd5; a_data = 32'hDEADBEEF;
    #1;
    check("alu_a_ready", 32'(a_ready), 32'd1);
    check("alu_l_ready", 32'(l_ready), 32'd0);
    @(negedge clk);
    idle_inputs();
    check_commit("alu", 1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    check("alu_we_off", 32'(we), 32'd0);
    check("alu_rf5", rf[5], 32'hDEADBEEF);

    // Contention on the same destination: L then A, x3 ends with A's value
    l_valid = 1'b1; l_ptr = 5'd3; l_data = 32'h11;
    a_valid = 1'b1; a_ptr = 5'd3; a_data = 32'h22;
    #1;
    check("cont_l_ready", 32'(l_ready), 32'd1);
    check("cont_a_ready0", 32'(a_ready), 32'd0);
    @(negedge clk);
    check_commit("cont_l", 1'b1, 5'd3, 32'h11);
    l_valid = 1'b0;
    #1;
    check("cont_a_ready1", 32'(a_ready), 32'd1);
    @(negedge clk);
    check_commit("cont_a", 1'b1, 5'd3, 32'h22);
    idle_inputs();
    @(negedge clk);
    check("cont_rf3", rf[3], 32'h22);

    // x0 write accepted and dropped; x0 issue never marks pending
    l_valid = 1'b1; l_ptr = 5'd0; l_data = 32'hFFFFFFFF;
    issue_valid = 1'b1; issue_ptr = 5'd0;
    #1;
    check("x0_l_ready", 32'(l_ready), 32'd1);
    @(negedge clk);
    idle_inputs();
    check("x0_we", 32'(we), 32'd0);
    check("x0_pending", pending, 32'h0);

    // Scoreboard: set, set-wins-over-clear, then clear
    issue_valid = 1'b1; issue_ptr = 5'd7;
    @(negedge clk);
    issue_valid = 1'b0;
    check("sb_set", pending, 32'h80);
    a_valid = 1'b1; a_ptr = 5'd7; a_data = 32'h77;
    #1;
    check("sb_a_ready1", 32'(a_ready), 32'd1);
    @(negedge clk);
    a_valid = 1'b0;
    check_commit("sb_c1", 1'b1, 5'd7, 32'h77);
    issue_valid = 1'b1; issue_ptr = 5'd7;
    @(negedge clk);
    issue_valid = 1'b0;
    check("sb_set_wins", pending, 32'h80);
    a_valid = 1'b1; a_data = 32'h78;
    @(negedge clk);
    a_valid = 1'b0;
    check_commit("sb_c2", 1'b1, 5'd7, 32'h78);
    @(negedge clk);
    check("sb_clear", pending, 32'h0);

    // Reset mid-operation squashes the commit and clears the scoreboard
    issue_valid = 1'b1; issue_ptr = 5'd9;
    a_valid = 1'b1; a_ptr = 5'd9; a_data = 32'h99;
    @(negedge clk);
    issue_valid = 1'b0; a_valid = 1'b0;
    check("mid_pending", pending, 32'h200);
    check("mid_we", 32'(we), 32'd1);
    rst = 1'b1; l_valid = 1'b1; l_ptr = 5'd4;
    #1;
    check("mid_rst_l_ready", 32'(l_ready), 32'd0);
    @(negedge clk);
    check("mid_rst_we", 32'(we), 32'd0);
    check("mid_rst_pending", pending, 32'h0);
    rst = 1'b0; idle_inputs();
    @(negedge clk);

    // Both ports continuously valid with distinct destinations
    lp = 5'd10; ld = 32'h100; ap = 5'd20; ad = 32'h200;
    l_valid = 1'b1; a_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      l_ptr = lp; l_data = ld; a_ptr = ap; a_data = ad;
      #1;
`ifdef WB_ARB_RR_EN
      exp_l = ((i % 2) == 0);
`else
      exp_l = 1'b1;
`endif
      check("arb_l_ready", 32'(l_ready), 32'(exp_l));
      check("arb_a_ready", 32'(a_ready), 32'(!exp_l));
      if (exp_l) exp_q.push_back({lp, ld});
      else       exp_q.push_back({ap, ad});
      @(negedge clk);
      e = exp_q.pop_front();
      check_commit("arb", 1'b1, e[36:32], e[31:0]);
      if (exp_l) begin lp = lp + 5'd1; ld = ld + 32'd1; end
      else       begin ap = ap + 5'd1; ad = ad + 32'd1; end
    end
    idle_inputs();
    @(negedge clk);
    check("arb_we_off", 32'(we), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
